// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage of the single-cycle RISC-V core. Owns the program counter,
// issues one instruction-memory read at a time, holds the returned
// instruction for decode, and applies branch redirects
// (branch_pc + sign-extended branch_imm).
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   imem_req_valid  out  fetch request valid (REQ state)
//   imem_req_ready  in   memory accepts the request this cycle
//   imem_addr       out  fetch address, always equal to pc
//   imem_rsp_valid  in   read data valid (only honoured in WAIT)
//   imem_rdata      in   read data
//   instr_valid     out  instruction available to decode (HOLD state)
//   instr_ready     in   decode consumes the instruction this cycle
//   instruction     out  registered instruction (NOP after reset)
//   instr_pc        out  PC of the presented instruction
//   branch_taken    in   presented instruction redirects fetch
//   branch_pc       in   branch base address
//   branch_imm      in   signed byte offset
//   misaligned      out  sticky flag: redirect target not 4-byte aligned
//
// Handshakes: a transfer happens on a cycle where both valid and ready are
// high. A valid, once raised, stays high with its payload stable until that
// transfer; ready may toggle freely and never depends on combinational
// feedback from valid inside this block.
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                  ADDRSIZE  = 32,
    parameter int                  INSTRSIZE = 32,
    parameter int                  IMMSIZE   = 32,
    parameter logic [ADDRSIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [ADDRSIZE-1:0]  imem_addr,
    input  logic                 imem_rsp_valid,
    input  logic [INSTRSIZE-1:0] imem_rdata,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [INSTRSIZE-1:0] instruction,
    output logic [ADDRSIZE-1:0]  instr_pc,
    input  logic                 branch_taken,
    input  logic [ADDRSIZE-1:0]  branch_pc,
    input  logic [IMMSIZE-1:0]   branch_imm,
    output logic                 misaligned
);

    localparam logic [INSTRSIZE-1:0] NOP = INSTRSIZE'(32'h0000_0013);

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDRSIZE-1:0] pc_q;
    logic [ADDRSIZE-1:0] imm_ext;
    logic [ADDRSIZE-1:0] tgt;
    logic                consume;
    logic                tgt_bad;

    // Immediate is sign-extended when narrower than the PC, truncated otherwise.
    generate
        if (IMMSIZE >= ADDRSIZE) begin : g_imm_trunc
            assign imm_ext = branch_imm[ADDRSIZE-1:0];
        end else begin : g_imm_sext
            assign imm_ext = {{(ADDRSIZE-IMMSIZE){branch_imm[IMMSIZE-1]}}, branch_imm};
        end
    endgenerate

    // Wraps modulo 2^ADDRSIZE by construction.
    assign tgt     = branch_pc + imm_ext;
    // Decode handshake; branch inputs are only looked at on this cycle.
    assign consume = (state_q == S_HOLD) && instr_ready;
    assign tgt_bad = branch_taken && (tgt[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ:  if (imem_req_ready) state_d = S_WAIT;
            S_WAIT: if (imem_rsp_valid) state_d = S_HOLD;
            S_HOLD: if (consume) state_d = tgt_bad ? S_ERR : S_REQ;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_BOOT;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        case (state_q)
            S_REQ:   imem_req_valid = 1'b1;
            S_HOLD:  instr_valid    = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr = pc_q;

    // Datapath: PC, presented instruction and the sticky error flag.
    // Responses arriving outside WAIT (including one left over from before a
    // reset) never reach these registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            instruction <= NOP;
            instr_pc    <= '0;
            misaligned  <= 1'b0;
        end else begin
            if ((state_q == S_WAIT) && imem_rsp_valid) begin
                instruction <= imem_rdata;
                instr_pc    <= pc_q;
            end
            if (consume) begin
                if (!branch_taken) begin
                    pc_q <= pc_q + ADDRSIZE'(4);
                end else if (!tgt_bad) begin
                    pc_q <= tgt;
                end else begin
                    misaligned <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (RESET_PC = 0)
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instruction, instr_pc;
  logic        branch_taken;
  logic [31:0] branch_pc, branch_imm;
  logic        misaligned;

  // wrap instance (RESET_PC = 0xFFFF_FFFC)
  logic        h_rst_n;
  logic        h_req_valid, h_req_ready;
  logic [31:0] h_addr;
  logic        h_rsp_valid;
  logic [31:0] h_rdata;
  logic        h_ivalid, h_iready;
  logic [31:0] h_instr, h_ipc;
  logic        h_mis;

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .branch_imm(branch_imm),
    .misaligned(misaligned)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(h_rst_n),
    .imem_req_valid(h_req_valid), .imem_req_ready(h_req_ready),
    .imem_addr(h_addr), .imem_rsp_valid(h_rsp_valid), .imem_rdata(h_rdata),
    .instr_valid(h_ivalid), .instr_ready(h_iready),
    .instruction(h_instr), .instr_pc(h_ipc),
    .branch_taken(1'b0), .branch_pc(32'h0), .branch_imm(32'h0),
    .misaligned(h_mis)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rr, rv;
    logic [31:0] rdata;
    logic        ir, bt;
    logic [31:0] bpc, bimm;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr, e_ipc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rr, logic rv, logic [31:0] rdata, logic ir, logic bt,
                             logic [31:0] bpc, logic [31:0] bimm, logic e_rv,
                             logic [31:0] e_addr, logic e_iv, logic [31:0] e_instr,
                             logic [31:0] e_ipc, logic e_mis);
    vec_t r;
    r.rr = rr; r.rv = rv; r.rdata = rdata; r.ir = ir; r.bt = bt; r.bpc = bpc; r.bimm = bimm;
    r.e_rv = e_rv; r.e_addr = e_addr; r.e_iv = e_iv; r.e_instr = e_instr; r.e_ipc = e_ipc;
    r.e_mis = e_mis;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    // Each row: inputs driven this cycle, outputs expected this cycle.
    //            rr rv rdata        ir bt bpc    bimm          rv addr          iv instr        ipc    mis
    vecs.push_back(v(0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0, 32'h0,  0, 32'h0000_0013, 32'h0,  0)); // BOOT
    vecs.push_back(v(1, 0, 32'h0,        0, 0, 32'h0,   32'h0,        1, 32'h0,  0, 32'h0,        32'h0,  0)); // REQ 0
    vecs.push_back(v(0, 1, 32'h0050_0093,0, 0, 32'h0,   32'h0,        0, 32'h0,  0, 32'h0,        32'h0,  0)); // WAIT
    vecs.push_back(v(0, 0, 32'h0,        1, 0, 32'h0,   32'h0,        0, 32'h0,  1, 32'h0050_0093, 32'h0,  0)); // HOLD
    vecs.push_back(v(1, 0, 32'h0,        0, 0, 32'h0,   32'h0,        1, 32'h4,  0, 32'h0,        32'h0,  0)); // REQ 4
    vecs.push_back(v(0, 1, 32'h0010_0113,0, 0, 32'h0,   32'h0,        0, 32'h0,  0, 32'h0,        32'h0,  0));
    vecs.push_back(v(0, 0, 32'h0,        1, 0, 32'h0,   32'h0,        0, 32'h0,  1, 32'h0010_0113, 32'h4,  0));
    vecs.push_back(v(1, 0, 32'h0,        0, 0, 32'h0,   32'h0,        1, 32'h8,  0, 32'h0,        32'h0,  0)); // REQ 8
    vecs.push_back(v(0, 1, 32'h0020_8193,0, 0, 32'h0,   32'h0,        0, 32'h0,  0, 32'h0,        32'h0,  0));
    vecs.push_back(v(0, 0, 32'h0,        1, 0, 32'h0,   32'h0,        0, 32'h0,  1, 32'h0020_8193, 32'h8,  0));
    // branch_taken outside the decode handshake must be ignored
    vecs.push_back(v(1, 0, 32'h0,        0, 1, 32'h100, 32'h0,        1, 32'hC,  0, 32'h0,        32'h0,  0)); // REQ C
    vecs.push_back(v(0, 1, 32'h0000_0033,0, 1, 32'h100, 32'h0,        0, 32'h0,  0, 32'h0,        32'h0,  0));
    vecs.push_back(v(0, 0, 32'h0,        1, 0, 32'h0,   32'h0,        0, 32'h0,  1, 32'h0000_0033, 32'hC,  0));
    vecs.push_back(v(1, 0, 32'h0,        0, 0, 32'h0,   32'h0,        1, 32'h10, 0, 32'h0,        32'h0,  0)); // REQ 10
    vecs.push_back(v(0, 1, 32'hFE00_0CE3,0, 0, 32'h0,   32'h0,        0, 32'h0,  0, 32'h0,        32'h0,  0));
    // taken backward branch: 0x10 + (-8) = 0x08
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 32'h10,  32'hFFFF_FFF8,0, 32'h0,  1, 32'hFE00_0CE3, 32'h10, 0));
    vecs.push_back(v(1, 0, 32'h0,        0, 0, 32'h0,   32'h0,        1, 32'h8,  0, 32'h0,        32'h0,  0)); // REQ 8
    vecs.push_back(v(0, 1, 32'h0030_0213,0, 0, 32'h0,   32'h0,        0, 32'h0,  0, 32'h0,        32'h0,  0));
    // misaligned target 0x10 + 6 = 0x16
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 32'h10,  32'h6,        0, 32'h0,  1, 32'h0030_0213, 32'h8,  0));
    // ERR: sticky flag, no valids whatever the inputs do
    vecs.push_back(v(1, 1, 32'h1234_5678,1, 0, 32'h0,   32'h0,        0, 32'h0,  0, 32'h0,        32'h0,  1));
    vecs.push_back(v(1, 1, 32'h1234_5678,1, 0, 32'h0,   32'h0,        0, 32'h0,  0, 32'h0,        32'h0,  1));
    vecs.push_back(v(1, 1, 32'h1234_5678,1, 0, 32'h0,   32'h0,        0, 32'h0,  0, 32'h0,        32'h0,  1));

    rst_n = 1'b0; h_rst_n = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rdata = '0; instr_ready = 0;
    branch_taken = 0; branch_pc = '0; branch_imm = '0;
    h_req_ready = 0; h_rsp_valid = 0; h_rdata = '0; h_iready = 0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ---- table: reset, straight-line, branches, misaligned ----
    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'(vecs[i].e_rv));
      chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(vecs[i].e_iv));
      chk({tag, ".misaligned"}, 32'(misaligned), 32'(vecs[i].e_mis));
      if (vecs[i].e_rv || i == 0) chk({tag, ".imem_addr"}, imem_addr, vecs[i].e_addr);
      if (vecs[i].e_iv || i == 0) begin
        chk({tag, ".instruction"}, instruction, vecs[i].e_instr);
        chk({tag, ".instr_pc"}, instr_pc, vecs[i].e_ipc);
      end
      imem_req_ready = vecs[i].rr;  imem_rsp_valid = vecs[i].rv; imem_rdata = vecs[i].rdata;
      instr_ready    = vecs[i].ir;  branch_taken   = vecs[i].bt;
      branch_pc      = vecs[i].bpc; branch_imm     = vecs[i].bimm;
      @(negedge clk);
    end

    // ---- backpressure on both ports; reset out of ERR ----
    rst_n = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; instr_ready = 0; branch_taken = 0;
    #1;
    chk("err_reset.misaligned", 32'(misaligned), 32'd0);
    chk("err_reset.req_valid", 32'(imem_req_valid), 32'd0);
    chk("err_reset.imem_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("bp.boot_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp.req_stall%0d.valid", k), 32'(imem_req_valid), 32'd1);
      chk($sformatf("bp.req_stall%0d.addr", k), imem_addr, 32'h0);
      imem_req_ready = 0;
      @(negedge clk);
    end
    chk("bp.req_accept.valid", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1;
    @(negedge clk);
    imem_req_ready = 0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("bp.wait%0d.instr_valid", k), 32'(instr_valid), 32'd0);
      chk($sformatf("bp.wait%0d.req_valid", k), 32'(imem_req_valid), 32'd0);
      @(negedge clk);
    end
    imem_rsp_valid = 1; imem_rdata = 32'h00A0_0513;
    @(negedge clk);
    imem_rsp_valid = 0; imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp.hold%0d.instr_valid", k), 32'(instr_valid), 32'd1);
      chk($sformatf("bp.hold%0d.instruction", k), instruction, 32'h00A0_0513);
      chk($sformatf("bp.hold%0d.instr_pc", k), instr_pc, 32'h0);
      chk($sformatf("bp.hold%0d.req_valid", k), 32'(imem_req_valid), 32'd0);
      instr_ready = 0;
      branch_taken = (k == 1); branch_pc = 32'h40; branch_imm = 32'h0;
      @(negedge clk);
    end
    chk("bp.release.instr_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1; branch_taken = 0;
    @(negedge clk);
    instr_ready = 0;
    chk("bp.next.req_valid", 32'(imem_req_valid), 32'd1);
    chk("bp.next.addr", imem_addr, 32'h4);
    chk("bp.next.instr_valid", 32'(instr_valid), 32'd0);

    // ---- RESET_PC = 0xFFFF_FFFC: wrap, reset in WAIT, stale response ----
    @(negedge clk);
    h_rst_n = 1'b1;
    chk("wrap.boot.req_valid", 32'(h_req_valid), 32'd0);
    @(negedge clk);
    chk("wrap.req1.valid", 32'(h_req_valid), 32'd1);
    chk("wrap.req1.addr", h_addr, 32'hFFFF_FFFC);
    h_req_ready = 1;
    @(negedge clk);
    h_req_ready = 0; h_rsp_valid = 1; h_rdata = 32'h0000_0011;
    @(negedge clk);
    h_rsp_valid = 0;
    chk("wrap.hold.instr_valid", 32'(h_ivalid), 32'd1);
    chk("wrap.hold.instr_pc", h_ipc, 32'hFFFF_FFFC);
    chk("wrap.hold.instruction", h_instr, 32'h0000_0011);
    h_iready = 1;
    @(negedge clk);
    h_iready = 0;
    chk("wrap.req2.valid", 32'(h_req_valid), 32'd1);
    chk("wrap.req2.addr", h_addr, 32'h0);
    h_req_ready = 1;
    @(negedge clk);
    h_req_ready = 0;
    chk("wrap.wait.req_valid", 32'(h_req_valid), 32'd0);
    h_rst_n = 1'b0;
    #1;
    chk("wrap.rst.addr", h_addr, 32'hFFFF_FFFC);
    chk("wrap.rst.instr_valid", 32'(h_ivalid), 32'd0);
    chk("wrap.rst.instruction", h_instr, 32'h0000_0013);
    h_rsp_valid = 1; h_rdata = 32'h0000_0BAD;
    @(negedge clk);
    h_rst_n = 1'b1;
    chk("wrap.reboot.req_valid", 32'(h_req_valid), 32'd0);
    @(negedge clk);
    chk("wrap.rereq.valid", 32'(h_req_valid), 32'd1);
    chk("wrap.rereq.addr", h_addr, 32'hFFFF_FFFC);
    chk("wrap.rereq.instr_valid", 32'(h_ivalid), 32'd0);
    h_rsp_valid = 0; h_req_ready = 1;
    @(negedge clk);
    h_req_ready = 0;
    chk("wrap.rewait.instr_valid", 32'(h_ivalid), 32'd0);
    h_rsp_valid = 1; h_rdata = 32'h0000_0022;
    @(negedge clk);
    h_rsp_valid = 0;
    chk("wrap.rehold.instr_valid", 32'(h_ivalid), 32'd1);
    chk("wrap.rehold.instruction", h_instr, 32'h0000_0022);
    chk("wrap.rehold.instr_pc", h_ipc, 32'hFFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
